// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and operand bundle between decode/CU and muldiv_unit.
interface muldiv_unit_if #(parameter int unsigned n = 32);
    logic         start;
    logic [2:0]   funct3;
    logic [n-1:0] rs1;
    logic [n-1:0] rs2;
    logic         busy;
    logic         done;
    logic [n-1:0] result;

    modport master (output start, funct3, rs1, rs2, input busy, done, result);
    modport slave  (input start, funct3, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial operations complete at the accepting edge.
module muldiv_unit #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(n);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [2:0]    op;
    logic [n-1:0]  opd;
    logic [n-1:0]  hi;
    logic [n-1:0]  lo;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          dz;
    logic [n-1:0]  dz_res;
    logic          busy_r;
    logic          done_r;
    logic [n-1:0]  res_r;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = res_r;

    // Operand decode at the accepting edge
    logic         in_div;
    logic         sgn1;
    logic         sgn2;
    logic         s1;
    logic         s2;
    logic         in_neg;
    logic         in_dz;
    logic [n-1:0] mag1;
    logic [n-1:0] mag2;
    logic [n-1:0] in_dz_res;

    always_comb begin
        in_div    = bus.funct3[2];
        sgn1      = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        sgn2      = sgn1 && (bus.funct3 != 3'b010);
        s1        = sgn1 & bus.rs1[n-1];
        s2        = sgn2 & bus.rs2[n-1];
        mag1      = s1 ? -bus.rs1 : bus.rs1;
        mag2      = s2 ? -bus.rs2 : bus.rs2;
        in_dz     = in_div && (bus.rs2 == '0);
        in_dz_res = bus.funct3[1] ? bus.rs1 : '1;
        if (!in_div)
            in_neg = s1 ^ s2;
        else if (bus.funct3[0])
            in_neg = 1'b0;
        else if (bus.funct3[1])
            in_neg = s1;
        else
            in_neg = s1 ^ s2;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic         in_ovf;
    logic         early;
    logic [n-1:0] early_res;

    always_comb begin
        in_ovf    = in_div && !bus.funct3[0] &&
                    (bus.rs1 == {1'b1, {(n-1){1'b0}}}) && (bus.rs2 == '1);
        early     = in_dz || in_ovf || (!in_div && ((bus.rs1 == '0) || (bus.rs2 == '0)));
        early_res = '0;
        if (in_dz)
            early_res = in_dz_res;
        else if (in_ovf && !bus.funct3[1])
            early_res = bus.rs1;
    end
`endif

    // One iteration: hi:lo is the product shift register (mul) or remainder:quotient (div)
    logic [n:0]   sum;
    logic [n:0]   rsh;
    logic [n:0]   diff;
    logic [n-1:0] nhi;
    logic [n-1:0] nlo;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        rsh  = {hi, lo[n-1]};
        diff = rsh - {1'b0, opd};
        if (op[2]) begin
            if (diff[n]) begin
                nhi = rsh[n-1:0];
                nlo = {lo[n-2:0], 1'b0};
            end else begin
                nhi = diff[n-1:0];
                nlo = {lo[n-2:0], 1'b1};
            end
        end else begin
            nhi = sum[n:1];
            nlo = {sum[0], lo[n-1:1]};
        end
    end

    // Sign fix-up and result selection, applied to the final iteration's values
    logic [2*n-1:0] prod;
    logic [n-1:0]   quo;
    logic [n-1:0]   rem;
    logic [n-1:0]   fin;

    always_comb begin
        prod = neg ? -{nhi, nlo} : {nhi, nlo};
        quo  = neg ? -nlo : nlo;
        rem  = neg ? -nhi : nhi;
        if (dz)
            fin = dz_res;
        else if (op[2])
            fin = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            fin = prod[n-1:0];
        else
            fin = prod[2*n-1:n];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op     <= '0;
            opd    <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            dz     <= 1'b0;
            dz_res <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            res_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op     <= bus.funct3;
                        neg    <= in_neg;
                        dz     <= in_dz;
                        dz_res <= in_dz_res;
                        cnt    <= '0;
                        opd    <= in_div ? mag2 : mag1;
                        hi     <= '0;
                        lo     <= in_div ? mag1 : mag2;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early) begin
                            res_r  <= early_res;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= CALC;
                        end
`else
                        busy_r <= 1'b1;
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(n - 1)) begin
                        res_r  <= fin;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned N = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_unit_if #(.n(N)) bus ();
    muldiv_unit #(.n(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa;
        int          sb;
        longint      la;
        longint      lb;
        longint      lua;
        longint      lub;
        logic [63:0] p;
        logic        ovf;
        sa  = a;
        sb  = b;
        la  = sa;
        lb  = sb;
        lua = longint'({32'b0, a});
        lub = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = la * lb;   return p[31:0];  end
            3'd1: begin p = la * lb;   return p[63:32]; end
            3'd2: begin p = la * lub;  return p[63:32]; end
            3'd3: begin p = lua * lub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit early_out(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2])
            return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    // Timeline model: accept edge e0 and latency decide busy/done/result per cycle
    longint      edge_no = 0;
    longint      e0 = 0;
    bit          have_op = 1'b0;
    bit          early_op = 1'b0;
    logic [31:0] exp_res = '0;
    logic [31:0] pend_res = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            have_op <= 1'b0;
            exp_res <= '0;
        end else begin
            edge_no <= edge_no + 1;
            if (bus.start && (!have_op || edge_no >= e0 + (early_op ? 0 : N) + 2)) begin
                e0       <= edge_no;
                have_op  <= 1'b1;
                early_op <= EARLY && early_out(bus.funct3, bus.rs1, bus.rs2);
                pend_res <= ref_model(bus.funct3, bus.rs1, bus.rs2);
                if (EARLY && early_out(bus.funct3, bus.rs1, bus.rs2))
                    exp_res <= ref_model(bus.funct3, bus.rs1, bus.rs2);
            end else if (have_op && !early_op && edge_no == e0 + N) begin
                exp_res <= pend_res;
            end
        end
    end

    always @(negedge clk) begin : cmp
        longint e;
        bit     xb;
        bit     xd;
        if (chk_en) begin
            e  = edge_no - 1;
            xb = have_op && !early_op && (e < e0 + N);
            xd = have_op && (e == e0 + (early_op ? 0 : N));
            check("busy", 32'(bus.busy), 32'(xb));
            check("done", 32'(bus.done), 32'(xd));
            check("result", bus.result, exp_res);
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        int w;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        w = 0;
        while (bus.done !== 1'b1 && w < 2 * N) begin
            bus.rs1    = $urandom;
            bus.rs2    = $urandom;
            bus.funct3 = 3'($urandom_range(7, 0));
            @(negedge clk);
            w++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * N);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3, 0) == 0) return specials[$urandom_range(4, 0)];
        return $urandom;
    endfunction

    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; } op_t;

    initial begin
        op_t dir [14];
        dir = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD},
            '{3'd1, 32'h8000_0000,  32'h8000_0000},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
            '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9,  32'd2},
            '{3'd6, 32'hFFFF_FFF9,  32'd2},
            '{3'd5, 32'd100,        32'd7},
            '{3'd7, 32'd100,        32'd7},
            '{3'd4, 32'd5,          32'd0},
            '{3'd7, 32'd5,          32'd0},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
            '{3'd0, 32'd0,          32'd12345},
            '{3'd6, 32'hFFFF_FFF0,  32'd0}
        };
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.rs1    = '0;
        bus.rs2    = '0;

        // Pin the reference model to hand-computed values
        check("pin_mul",    ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulh",   ref_model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("pin_mulhu",  ref_model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("pin_mulhsu", ref_model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin_div",    ref_model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("pin_rem",    ref_model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("pin_divu",   ref_model(3'd5, 32'd100, 32'd7), 32'd14);
        check("pin_remu",   ref_model(3'd7, 32'd100, 32'd7), 32'd2);
        check("pin_div0",   ref_model(3'd4, 32'd5, 32'd0), 32'hFFFF_FFFF);
        check("pin_remu0",  ref_model(3'd7, 32'd5, 32'd0), 32'd5);
        check("pin_ovf",    ref_model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("pin_removf", ref_model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_result", bus.result, 32'h0);
        chk_en = 1'b1;
        #2 rst = 1'b1;

        foreach (dir[i]) run_op(dir[i].f, dir[i].a, dir[i].b, 1'b0);

        // start held through a whole operation while operands wander
        run_op(3'd0, 32'd3, 32'd4, 1'b1);
        check("hold_mul", bus.result, 32'd12);
        run_op(3'd0, 32'd5, 32'd6, 1'b0);
        check("back_to_back", bus.result, 32'd30);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.rs1    = 32'd100;
        bus.rs2    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_result", bus.result, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        run_op(3'd0, 32'd2, 32'd3, 1'b0);
        check("post_reset_mul", bus.result, 32'd6);

        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            run_op(3'($urandom_range(7, 0)), pick_operand(), pick_operand(), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes rs1/rs2 operand values plus funct3 from decode, and produces one n-bit result for writeback.
- Uses a start/busy/done handshake; the CU stalls the pipeline while busy is high.
- Radix-2 design: one bit per cycle, shift-add for multiply, restoring algorithm for divide.

Parameters:
n, 32, operand/result width in bits (must be even and >= 4)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-low reset
start  input  1  operation request; sampled at a rising edge, accepted only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  n  operand A (multiplicand or dividend)
rs2  input  n  operand B (multiplier or divisor)
busy  output  1  high while an accepted operation is computing
done  output  1  one-cycle pulse; result is valid from this cycle on
result  output  n  registered result, held until the next completion or reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal operand/accumulator registers=0.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
  - IDLE: when start=1 at edge E0, latch funct3 and the operand magnitudes, record the result sign, clear the counter, go to CALC.
  - CALC: one iteration per edge. After the n-th iteration (edge E0+n), load result and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start in CALC or DONE is ignored; the request is not queued. rs1/rs2/funct3 may change freely after E0.
- Timing: busy=1 from E0 to E0+n (n cycles); done=1 from E0+n to E0+n+1. A new start can be accepted at E0+n+2 at the earliest.
- Multiply:
  - 2n-bit unsigned shift-add on the magnitudes.
  - MUL and MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - The 2n-bit product is two's-complement negated when the operand signs differ.
  - MUL returns product[n-1:0]; MULH/MULHSU/MULHU return product[2n-1:n].
- Divide:
  - Restoring division on the magnitudes.
  - DIV: quotient negated when the signs differ.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: no sign handling.
- Special cases (RISC-V defined; computed in CALC with the same n-cycle latency):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = -2^(n-1), rs2 = -1): DIV returns -2^(n-1); REM returns 0.
- Magnitude of -2^(n-1) is 2^(n-1), held in n bits unsigned with no overflow.
- result changes only on entry to DONE or on reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: the following bypass CALC at the accepting edge E0 and go straight to DONE with result loaded (done=1 from E0 to E0+1; busy never asserts):
  - divide by zero
  - signed division overflow
  - either multiply operand equal to 0 (result 0)
- Not defined: every operation takes the uniform n-cycle path. No early-out logic is synthesised.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (n=32) -> result=0xFFFFFFEB; busy high exactly 32 cycles; done pulses once, 32 cycles after the start edge.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Without the macro each takes 32 cycles; with MULDIV_EARLY_OUT_EN, done is asserted in the cycle right after the start edge.
- Hold start=1 through a whole MUL 3×4 while changing rs1/rs2 during CALC -> result=12; exactly one operation executes; the next start is accepted only after return to IDLE.
- Start DIVU 100/7, drive rst=0 10 cycles later -> busy=0, done=0, result=0 immediately (asynchronously); after release, a new MUL 2×3 completes with result=6.
